// File: rtl/motion_alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : motion_alarm_ctrl
// Brief    : PIR synchronise/debounce plus arm/disarm/alarm controller
// Revision : 1.0 - initial release
// ============================================================================
module motion_alarm_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ARM_DELAY       = 8,
    parameter int ALARM_TIMEOUT   = 64,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             turn,
    input  logic             stop_alarm,
    input  logic             pir_sensor_1,
    input  logic             pir_sensor_2,
    input  logic             pir_sensor_3,
    output logic             alarm,
    output logic             armed,
    output logic [2:0]       zone,
    output logic [CNT_W-1:0] event_count,
    output logic [1:0]       state_o
);

    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMR_MAX = (ARM_DELAY > ALARM_TIMEOUT) ? ARM_DELAY : ALARM_TIMEOUT;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [DB_W-1:0]  C_DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] C_ARM_LAST   = TMR_W'(ARM_DELAY - 1);
    localparam logic [TMR_W-1:0] C_ALARM_LAST = TMR_W'((ALARM_TIMEOUT > 0) ? ALARM_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] C_CNT_MAX    = {CNT_W{1'b1}};

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMING = 2'd1;
    localparam logic [1:0] S_ARMED  = 2'd2;
    localparam logic [1:0] S_ALARM  = 2'd3;

    logic [2:0] w_pin;
    logic [2:0] w_det;

    assign w_pin = {pir_sensor_3, pir_sensor_2, pir_sensor_1};

    // Per-channel synchroniser followed by a consecutive-high debounce counter.
    for (genvar i = 0; i < 3; i++) begin : g_chan
        logic [SYNC_STAGES-1:0] r_sync;
        logic [DB_W-1:0]        r_db_cnt;
        logic                   r_det;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync   <= '0;
                r_db_cnt <= '0;
                r_det    <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_pin[i]};
                if (!r_sync[SYNC_STAGES-1]) begin
                    r_db_cnt <= '0;
                    r_det    <= 1'b0;
                end else if (r_db_cnt == C_DB_LAST) begin
                    r_det    <= 1'b1;
                end else begin
                    r_db_cnt <= r_db_cnt + DB_W'(1);
                end
            end
        end

        assign w_det[i] = r_det;
    end

    logic [1:0]       r_state;
    logic [TMR_W-1:0] r_timer;
    logic [2:0]       r_zone;
    logic [CNT_W-1:0] r_count;
    logic             r_alarm;
    logic             r_armed;

    logic [1:0]       w_state_nxt;
    logic [TMR_W-1:0] w_timer_nxt;
    logic [2:0]       w_zone_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [2:0]       w_zone_base;
    logic             w_alarm_nxt;
    logic             w_armed_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_zone  <= '0;
            r_count <= '0;
            r_alarm <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_zone  <= w_zone_nxt;
            r_count <= w_count_nxt;
            r_alarm <= w_alarm_nxt;
            r_armed <= w_armed_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_zone_nxt  = r_zone;
        w_count_nxt = r_count;
        w_zone_base = stop_alarm ? 3'b000 : r_zone;
        if (!turn) begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
            w_zone_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_ARMING;
                    w_timer_nxt = '0;
                end
                S_ARMING: begin
                    if (r_timer == C_ARM_LAST) begin
                        w_state_nxt = S_ARMED;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + TMR_W'(1);
                    end
                end
                S_ARMED: begin
                    // An acknowledge in the same cycle as a detection still alarms,
                    // but only the fresh zones are reported.
                    w_zone_nxt = w_zone_base;
                    if (|w_det) begin
                        w_state_nxt = S_ALARM;
                        w_zone_nxt  = w_zone_base | w_det;
                        w_timer_nxt = '0;
                        if (r_count != C_CNT_MAX) begin
                            w_count_nxt = r_count + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    if (stop_alarm) begin
                        w_state_nxt = S_ARMED;
                        w_zone_nxt  = '0;
                        w_timer_nxt = '0;
                    end else begin
                        w_zone_nxt = r_zone | w_det;
                        if ((ALARM_TIMEOUT != 0) && (r_timer == C_ALARM_LAST)) begin
                            w_state_nxt = S_ARMED;
                            w_timer_nxt = '0;
                        end else begin
                            w_timer_nxt = r_timer + TMR_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_alarm_nxt = (w_state_nxt == S_ALARM);
        w_armed_nxt = (w_state_nxt == S_ARMED) || (w_state_nxt == S_ALARM);
    end

    assign alarm       = r_alarm;
    assign armed       = r_armed;
    assign zone        = r_zone;
    assign event_count = r_count;
    assign state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_motion_alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_motion_alarm_ctrl
// Brief    : directed self-checking bench for motion_alarm_ctrl (CNT_W = 2)
// Revision : 1.0 - initial release
// ============================================================================
module tb_motion_alarm_ctrl;

    logic       clk;
    logic       rst_n;
    logic       turn;
    logic       stop_alarm;
    logic       pir_sensor_1;
    logic       pir_sensor_2;
    logic       pir_sensor_3;
    logic       alarm;
    logic       armed;
    logic [2:0] zone;
    logic [1:0] event_count;
    logic [1:0] state_o;

    int checks;
    int errors;

    motion_alarm_ctrl #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .ARM_DELAY       (8),
        .ALARM_TIMEOUT   (64),
        .CNT_W           (2)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .turn         (turn),
        .stop_alarm   (stop_alarm),
        .pir_sensor_1 (pir_sensor_1),
        .pir_sensor_2 (pir_sensor_2),
        .pir_sensor_3 (pir_sensor_3),
        .alarm        (alarm),
        .armed        (armed),
        .zone         (zone),
        .event_count  (event_count),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_alarm(input string tag);
        int n;
        n = 0;
        while (alarm !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, {31'd0, alarm}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        turn         = 1'b0;
        stop_alarm   = 1'b0;
        pir_sensor_1 = 1'b0;
        pir_sensor_2 = 1'b0;
        pir_sensor_3 = 1'b0;

        tick();
        tick();
        check("rst_state", {30'd0, state_o}, 32'd0);
        check("rst_alarm", {31'd0, alarm}, 32'd0);
        check("rst_armed", {31'd0, armed}, 32'd0);
        check("rst_zone", {29'd0, zone}, 32'd0);
        check("rst_count", {30'd0, event_count}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_hold", {30'd0, state_o}, 32'd0);

        // Exit delay: ARMING for exactly 8 observed cycles.
        turn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("arming", {30'd0, state_o}, 32'd1);
        end
        tick();
        check("armed_state", {30'd0, state_o}, 32'd2);
        check("armed_flag", {31'd0, armed}, 32'd1);
        check("armed_alarm", {31'd0, alarm}, 32'd0);
        check("armed_zone", {29'd0, zone}, 32'd0);

        // Zones 0 and 2: alarm rises exactly 6 edges after first sampling.
        pir_sensor_1 = 1'b1;
        pir_sensor_3 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("latency_low", {31'd0, alarm}, 32'd0);
        end
        tick();
        check("latency_high", {31'd0, alarm}, 32'd1);
        check("alarm1_zone", {29'd0, zone}, 32'd5);
        check("alarm1_count", {30'd0, event_count}, 32'd1);

        // Silence with PIR low.
        pir_sensor_1 = 1'b0;
        pir_sensor_3 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("still_alarm", {30'd0, state_o}, 32'd3);
        stop_alarm = 1'b1;
        tick();
        stop_alarm = 1'b0;
        check("stop_state", {30'd0, state_o}, 32'd2);
        check("stop_alarm", {31'd0, alarm}, 32'd0);
        check("stop_zone", {29'd0, zone}, 32'd0);
        check("stop_count", {30'd0, event_count}, 32'd1);

        // Short glitch on zone 1 is rejected.
        pir_sensor_2 = 1'b1;
        tick();
        tick();
        pir_sensor_2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("glitch_noalarm", {31'd0, alarm}, 32'd0);
        end
        check("glitch_zone", {29'd0, zone}, 32'd0);
        check("glitch_count", {30'd0, event_count}, 32'd1);

        // Second episode, then stop with PIR still high re-enters ALARM.
        pir_sensor_1 = 1'b1;
        wait_alarm("alarm2");
        check("alarm2_count", {30'd0, event_count}, 32'd2);
        check("alarm2_zone", {29'd0, zone}, 32'd1);
        stop_alarm = 1'b1;
        tick();
        stop_alarm = 1'b0;
        check("stop2_state", {30'd0, state_o}, 32'd2);
        check("stop2_zone", {29'd0, zone}, 32'd0);
        tick();
        check("realarm_state", {30'd0, state_o}, 32'd3);
        check("realarm_count", {30'd0, event_count}, 32'd3);
        check("realarm_zone", {29'd0, zone}, 32'd1);

        // Timeout: 64 cycles in ALARM then ARMED with zone retained.
        pir_sensor_1 = 1'b0;
        for (int i = 0; i < 63; i++) tick();
        check("pre_timeout", {30'd0, state_o}, 32'd3);
        tick();
        check("timeout_state", {30'd0, state_o}, 32'd2);
        check("timeout_zone", {29'd0, zone}, 32'd1);
        check("timeout_alarm", {31'd0, alarm}, 32'd0);
        check("timeout_armed", {31'd0, armed}, 32'd1);

        // Stop coincident with a detection in ARMED: zone becomes det only.
        pir_sensor_2 = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("pre_coinc_zone", {29'd0, zone}, 32'd1);
        stop_alarm = 1'b1;
        tick();
        stop_alarm = 1'b0;
        check("coinc_state", {30'd0, state_o}, 32'd3);
        check("coinc_zone", {29'd0, zone}, 32'd2);
        check("sat_count4", {30'd0, event_count}, 32'd3);
        tick();
        stop_alarm = 1'b1;
        tick();
        stop_alarm = 1'b0;
        check("stop3_state", {30'd0, state_o}, 32'd2);
        tick();
        check("ep5_state", {30'd0, state_o}, 32'd3);
        check("sat_count5", {30'd0, event_count}, 32'd3);

        // Disarm dominates.
        turn = 1'b0;
        tick();
        pir_sensor_2 = 1'b0;
        check("disarm_state", {30'd0, state_o}, 32'd0);
        check("disarm_armed", {31'd0, armed}, 32'd0);
        check("disarm_alarm", {31'd0, alarm}, 32'd0);
        check("disarm_zone", {29'd0, zone}, 32'd0);
        check("disarm_count", {30'd0, event_count}, 32'd3);

        // Toggling turn mid-ARMING restarts the exit delay.
        turn = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        turn = 1'b0;
        tick();
        check("restart_idle", {30'd0, state_o}, 32'd0);
        turn = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) tick();
        check("restart_arming", {30'd0, state_o}, 32'd1);
        tick();
        check("restart_armed", {30'd0, state_o}, 32'd2);

        // Asynchronous reset in the middle of ALARM.
        pir_sensor_3 = 1'b1;
        wait_alarm("alarm_pre_rst");
        check("pre_rst_zone", {29'd0, zone}, 32'd4);
        #5;
        rst_n = 1'b0;
        #1;
        check("arst_alarm", {31'd0, alarm}, 32'd0);
        check("arst_armed", {31'd0, armed}, 32'd0);
        check("arst_zone", {29'd0, zone}, 32'd0);
        check("arst_state", {30'd0, state_o}, 32'd0);
        check("arst_count", {30'd0, event_count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
